regfile_wb_arbiter: RTL and testbench

Writeback arbiter that shares the register file's single write port between two producers. Requester A is the in-order execute writeback and requester B is the long-latency unit (load / mul-div). It sits directly in front of the register file's `rd_we`/`rd_addr`/`rd_data` inputs and drives them from a registered output stage. Priority is fixed with A winning, plus a bounded-wait guarantee for B.

---
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 tb/tb_regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two producers, the arbiter and the register file write port.
// The arbiter takes the slave modport. The master side drives the requests and observes the write port.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  b_wait_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rd_we, rd_addr, rd_data, b_wait_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rd_we, rd_addr, rd_data, b_wait_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between requesters A and B. A has fixed priority.
// Defining WB_ARB_STARVE_EN adds a bounded-wait guarantee for B; otherwise A has strict priority.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  logic        a_comp;
  logic        b_comp;
  logic        force_b;
  logic        grant_a;
  logic        grant_b;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data_q;

  // x0 writes are consumed without using the port, so only non-x0 requests compete.
  assign a_comp = bus.a_valid && (bus.a_addr != 5'd0);
  assign b_comp = bus.b_valid && (bus.b_addr != 5'd0);

`ifdef WB_ARB_STARVE_EN
  logic [7:0] wait_cnt;

  assign force_b = (wait_cnt == 8'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (b_comp && !grant_b) begin
      if (!force_b) wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  assign bus.b_wait_cnt = wait_cnt;
`else
  assign force_b        = 1'b0;
  assign bus.b_wait_cnt = 8'd0;
`endif

  assign bus.a_ready = bus.a_valid && (!a_comp || !(b_comp && force_b));
  assign bus.b_ready = bus.b_valid && (!b_comp || !a_comp || force_b);

  assign grant_a = a_comp && bus.a_ready;
  assign grant_b = b_comp && bus.b_ready;

  // Address and data hold their last values when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
    end else begin
      rd_we_q <= grant_a || grant_b;
      if (grant_a) begin
        rd_addr_q <= bus.a_addr;
        rd_data_q <= bus.a_data;
      end else if (grant_b) begin
        rd_addr_q <= bus.b_addr;
        rd_data_q <= bus.b_data;
      end
    end
  end

  assign bus.rd_we   = rd_we_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. A small register-file model commits rd_* writes.
// Expectations follow WB_ARB_STARVE_EN, so the bench can be compiled with or without it.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32] = '{default: 32'd0};
  bit          x0_write = 1'b0;

  always @(posedge clk) begin
    if (bus.rd_we) begin
      rf[bus.rd_addr] <= bus.rd_data;
      if (bus.rd_addr == 5'd0) x0_write <= 1'b1;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_addr = 5'd0; bus.a_data = 32'd0;
    bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we: got %0b want 0", bus.rd_we); end
    n_checks++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
    n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h want 0", bus.rd_data); end
    n_checks++; if (bus.b_wait_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_wait_cnt: got %0d want 0", bus.b_wait_cnt); end
    bus.a_valid = 1'b1; bus.a_addr = 5'd5;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %0b want 1", bus.a_ready); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_a();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %0b want 1", bus.a_ready); end
    n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL single_b_ready: got %0b want 0", bus.b_ready); end
    tick();
    idle();
    n_checks++; if (bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL single_rd_we: got %0b want 1", bus.rd_we); end
    n_checks++; if (bus.rd_addr !== 5'd5) begin n_fail++; $display("FAIL single_rd_addr: got %0d want 5", bus.rd_addr); end
    n_checks++; if (bus.rd_data !== 32'h1234) begin n_fail++; $display("FAIL single_rd_data: got %0h want 1234", bus.rd_data); end
    tick();
    n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL single_rd_we_drop: got %0b want 0", bus.rd_we); end
    n_checks++; if (bus.rd_addr !== 5'd5) begin n_fail++; $display("FAIL single_rd_addr_hold: got %0d want 5", bus.rd_addr); end
    n_checks++; if (rf[5] !== 32'h1234) begin n_fail++; $display("FAIL single_commit: got %0h want 1234", rf[5]); end
  endtask

  task automatic test_both_compete();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'hB;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL both_a_ready: got %0b want 1", bus.a_ready); end
    n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL both_b_ready: got %0b want 0", bus.b_ready); end
    tick();
    bus.a_valid = 1'b0;
    n_checks++; if (bus.rd_addr !== 5'd3 || bus.rd_data !== 32'hA || bus.rd_we !== 1'b1)
      begin n_fail++; $display("FAIL both_first: got we=%0b addr=%0d data=%0h want we=1 addr=3 data=a", bus.rd_we, bus.rd_addr, bus.rd_data); end
    n_checks++; if (bus.b_wait_cnt !== (STARVE ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL both_wait_cnt: got %0d want %0d", bus.b_wait_cnt, STARVE ? 1 : 0); end
    #1;
    n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL both_b_ready2: got %0b want 1", bus.b_ready); end
    tick();
    idle();
    n_checks++; if (bus.rd_addr !== 5'd7 || bus.rd_data !== 32'hB || bus.rd_we !== 1'b1)
      begin n_fail++; $display("FAIL both_second: got we=%0b addr=%0d data=%0h want we=1 addr=7 data=b", bus.rd_we, bus.rd_addr, bus.rd_data); end
    n_checks++; if (bus.b_wait_cnt !== 8'd0) begin n_fail++; $display("FAIL both_wait_clear: got %0d want 0", bus.b_wait_cnt); end
    tick();
    n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL both_idle: got %0b want 0", bus.rd_we); end
  endtask

  task automatic test_x0();
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h55;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1)
      begin n_fail++; $display("FAIL x0_ready: got a=%0b b=%0b want a=1 b=1", bus.a_ready, bus.b_ready); end
    tick();
    idle();
    n_checks++; if (bus.rd_addr !== 5'd9 || bus.rd_data !== 32'h55 || bus.rd_we !== 1'b1)
      begin n_fail++; $display("FAIL x0_write: got we=%0b addr=%0d data=%0h want we=1 addr=9 data=55", bus.rd_we, bus.rd_addr, bus.rd_data); end
    tick();
    n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL x0_single: got %0b want 0", bus.rd_we); end
  endtask

  task automatic test_starvation();
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h77;
    for (int k = 0; k < 4; k++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h100 + 32'(k);
      #1;
      n_checks++; if (bus.b_wait_cnt !== (STARVE ? 8'(k) : 8'd0)) begin n_fail++; $display("FAIL starve_cnt_%0d: got %0d want %0d", k, bus.b_wait_cnt, STARVE ? k : 0); end
      n_checks++; if (bus.b_ready !== 1'b0 || bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready_%0d: got a=%0b b=%0b want a=1 b=0", k, bus.a_ready, bus.b_ready); end
      tick();
      n_checks++; if (bus.rd_addr !== 5'd1 || bus.rd_data !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL starve_a_%0d: got addr=%0d data=%0h want addr=1 data=%0h", k, bus.rd_addr, bus.rd_data, 32'h100 + 32'(k)); end
    end
    bus.a_data = 32'h104;
    #1;
    n_checks++; if (bus.b_wait_cnt !== (STARVE ? 8'd4 : 8'd0)) begin n_fail++; $display("FAIL starve_cnt_4: got %0d want %0d", bus.b_wait_cnt, STARVE ? 4 : 0); end
    n_checks++; if (bus.b_ready !== STARVE || bus.a_ready !== !STARVE) begin n_fail++; $display("FAIL starve_force: got a=%0b b=%0b want a=%0b b=%0b", bus.a_ready, bus.b_ready, !STARVE, STARVE); end
    if (!STARVE) begin
      // Strict priority: A takes this slot, then B runs once A drops valid.
      tick();
      bus.a_valid = 1'b0;
      #1;
      n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL strict_b_ready: got %0b want 1", bus.b_ready); end
    end
    tick();
    bus.b_valid = 1'b0;
    n_checks++; if (bus.rd_addr !== 5'd2 || bus.rd_data !== 32'h77 || bus.rd_we !== 1'b1)
      begin n_fail++; $display("FAIL starve_b_write: got we=%0b addr=%0d data=%0h want we=1 addr=2 data=77", bus.rd_we, bus.rd_addr, bus.rd_data); end
    n_checks++; if (bus.b_wait_cnt !== 8'd0) begin n_fail++; $display("FAIL starve_cnt_clear: got %0d want 0", bus.b_wait_cnt); end
    if (STARVE) begin
      #1;
      n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL starve_a_resume: got %0b want 1", bus.a_ready); end
      tick();
      n_checks++; if (bus.rd_addr !== 5'd1 || bus.rd_data !== 32'h104) begin n_fail++; $display("FAIL starve_a_after: got addr=%0d data=%0h want addr=1 data=104", bus.rd_addr, bus.rd_data); end
    end
    idle();
    tick();
  endtask

  task automatic test_same_addr();
    bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h2;
    tick();
    bus.a_valid = 1'b0;
    n_checks++; if (bus.rd_data !== 32'h1) begin n_fail++; $display("FAIL same_first: got %0h want 1", bus.rd_data); end
    tick();
    idle();
    n_checks++; if (bus.rd_data !== 32'h2 || bus.rd_addr !== 5'd4) begin n_fail++; $display("FAIL same_second: got addr=%0d data=%0h want addr=4 data=2", bus.rd_addr, bus.rd_data); end
    tick();
    n_checks++; if (rf[4] !== 32'h2) begin n_fail++; $display("FAIL same_final: got %0h want 2", rf[4]); end
  endtask

  task automatic test_reset_mid();
    bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 32'hDEAD;
    bus.b_valid = 1'b1; bus.b_addr = 5'd8; bus.b_data = 32'hBEEF;
    tick();
    idle();
    n_checks++; if (bus.rd_we !== 1'b1 || bus.b_wait_cnt !== (STARVE ? 8'd1 : 8'd0))
      begin n_fail++; $display("FAIL mid_pre: got we=%0b cnt=%0d want we=1 cnt=%0d", bus.rd_we, bus.b_wait_cnt, STARVE ? 1 : 0); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.rd_we !== 1'b0 || bus.rd_addr !== 5'd0 || bus.rd_data !== 32'd0 || bus.b_wait_cnt !== 8'd0)
      begin n_fail++; $display("FAIL mid_async: got we=%0b addr=%0d data=%0h cnt=%0d want all 0", bus.rd_we, bus.rd_addr, bus.rd_data, bus.b_wait_cnt); end
    tick();
    n_checks++; if (rf[6] !== 32'd0) begin n_fail++; $display("FAIL mid_no_commit: got %0h want 0", rf[6]); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_both_compete();
    test_x0();
    test_starvation();
    test_same_addr();
    test_reset_mid();
    n_checks++; if (x0_write !== 1'b0) begin n_fail++; $display("FAIL x0_never: got %0b want 0", x0_write); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
